rf_access_master: RTL and testbench

Initiator for the register-file software interface: it accepts single read/write commands on a valid/ready port and drives `address`, `read_en`, `write_en` and `write_data` into a generated register-file block. It waits for `access_complete`, then returns read data and a status code on a valid/ready response port. It sits between the host-side command decoder and one register-file instance, and covers both fast register fields and multi-cycle RAM-backed regions through a bounded wait with timeout.

---
 rtl/rf_access_master_pkg.sv | 22 ++
 rtl/rf_access_master_if.sv | 52 +++++
 rtl/rf_access_master_timeout.sv | 29 ++
 rtl/rf_access_master.sv | 145 ++++++++++++++
 tb/tb_rf_access_master.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_access_master_pkg.sv
// Shared types and constants for the register-file access master.
package rf_master_pkg;

    // Access sequencing: accept a command, strobe once, wait, present response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rf_state_e;

    // Response status codes; 2'b11 is reserved and never produced.
    localparam logic [1:0] RF_ST_OK      = 2'b00;
    localparam logic [1:0] RF_ST_INVALID = 2'b01;
    localparam logic [1:0] RF_ST_TIMEOUT = 2'b10;

    // Status to report when the register file signals completion.
    function automatic logic [1:0] rf_complete_status(input logic invalid);
        return invalid ? RF_ST_INVALID : RF_ST_OK;
    endfunction

endpackage

// File: rtl/rf_access_master_if.sv
// Host-side command/response port and register-file side bus.

// Command/response channel. The host is the master, the access block the slave.
interface rf_cmd_if #(
    parameter int RF_ADDR_MSB = 10,
    parameter int DATA_WIDTH  = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [RF_ADDR_MSB:3]   cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_write;
    logic [DATA_WIDTH-1:0]  rsp_rdata;
    logic [1:0]             rsp_status;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_status
    );
endinterface

// Register-file access bus. The access block is the master, the register file the slave.
interface rf_bus_if #(
    parameter int RF_ADDR_MSB = 10,
    parameter int DATA_WIDTH  = 32
);
    logic [RF_ADDR_MSB:3]   address;
    logic                   read_en;
    logic                   write_en;
    logic [DATA_WIDTH-1:0]  write_data;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   invalid_address;
    logic                   access_complete;

    modport master (
        output address, read_en, write_en, write_data,
        input  read_data, invalid_address, access_complete
    );

    modport slave (
        input  address, read_en, write_en, write_data,
        output read_data, invalid_address, access_complete
    );
endinterface

// File: rtl/rf_access_master_timeout.sv
// Wait-cycle counter: cleared during the strobe cycle, counts while waiting,
// and flags the last allowed wait cycle.
module rf_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic clk,
    input  logic res,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_WIDTH-1:0] LAST_COUNT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count_reg;

    // Count wait cycles; hold at the last value so the counter never wraps.
    always_ff @(posedge clk) begin
        if (res || clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + TO_WIDTH'(1);
        end
    end

    assign expire = (count_reg == LAST_COUNT);

endmodule

// File: rtl/rf_access_master.sv
// Single-outstanding register-file access master: takes one command, strobes
// the register file once, waits for completion or timeout, returns a response.
module rf_access_master
    import rf_master_pkg::*;
#(
    parameter int RF_ADDR_MSB    = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic      clk,
    input  logic      res,
    rf_cmd_if.slave   cmd,
    rf_bus_if.master  rf
);

    rf_state_e              state_reg, state_next;
    logic [RF_ADDR_MSB:3]   address_reg, address_next;
    logic [DATA_WIDTH-1:0]  write_data_reg, write_data_next;
    logic                   read_en_reg, read_en_next;
    logic                   write_en_reg, write_en_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic                   rsp_write_reg, rsp_write_next;
    logic [1:0]             rsp_status_reg, rsp_status_next;
    logic [DATA_WIDTH-1:0]  rsp_rdata_reg, rsp_rdata_next;

    logic                   cnt_clear;
    logic                   cnt_enable;
    logic                   cnt_expire;
    logic                   read_ok;
    logic [DATA_WIDTH-1:0]  rdata_gated;

    rf_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timeout (
        .clk    (clk),
        .res    (res),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expire (cnt_expire)
    );

    // Read data only propagates for a successful read; writes and errors return zero.
    assign read_ok = !rsp_write_reg && !rf.invalid_address;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rdata_gate
        assign rdata_gated[gi] = rf.read_data[gi] & read_ok;
    end

    // State and registered outputs; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg      <= IDLE;
            address_reg    <= '0;
            write_data_reg <= '0;
            read_en_reg    <= 1'b0;
            write_en_reg   <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_write_reg  <= 1'b0;
            rsp_status_reg <= RF_ST_OK;
            rsp_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            address_reg    <= address_next;
            write_data_reg <= write_data_next;
            read_en_reg    <= read_en_next;
            write_en_reg   <= write_en_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_write_reg  <= rsp_write_next;
            rsp_status_reg <= rsp_status_next;
            rsp_rdata_reg  <= rsp_rdata_next;
        end
    end

    // Next-state and next-output logic; completion is only honoured in WAIT.
    always_comb begin
        state_next      = state_reg;
        address_next    = address_reg;
        write_data_next = write_data_reg;
        read_en_next    = read_en_reg;
        write_en_next   = write_en_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_write_next  = rsp_write_reg;
        rsp_status_next = rsp_status_reg;
        rsp_rdata_next  = rsp_rdata_reg;
        cnt_clear       = 1'b0;
        cnt_enable      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    // Strobes are registered, so they are set here to be high in ISSUE.
                    address_next    = cmd.cmd_addr;
                    write_data_next = cmd.cmd_wdata;
                    rsp_write_next  = cmd.cmd_write;
                    read_en_next    = !cmd.cmd_write;
                    write_en_next   = cmd.cmd_write;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                read_en_next  = 1'b0;
                write_en_next = 1'b0;
                cnt_clear     = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                cnt_enable = 1'b1;
                if (rf.access_complete) begin
                    rsp_status_next = rf_complete_status(rf.invalid_address);
                    rsp_rdata_next  = rdata_gated;
                    rsp_valid_next  = 1'b1;
                    state_next      = RESP;
                end else if (cnt_expire) begin
                    rsp_status_next = RF_ST_TIMEOUT;
                    rsp_rdata_next  = '0;
                    rsp_valid_next  = 1'b1;
                    state_next      = RESP;
                end
            end
            RESP: begin
                if (cmd.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready  = (state_reg == IDLE) && !res;
    assign cmd.rsp_valid  = rsp_valid_reg;
    assign cmd.rsp_write  = rsp_write_reg;
    assign cmd.rsp_status = rsp_status_reg;
    assign cmd.rsp_rdata  = rsp_rdata_reg;

    assign rf.address     = address_reg;
    assign rf.read_en     = read_en_reg;
    assign rf.write_en    = write_en_reg;
    assign rf.write_data  = write_data_reg;

endmodule

// File: tb/tb_rf_access_master.sv
// Randomized bench for rf_access_master with a behavioural register-file model.
module tb_rf_access_master;

    localparam int AMSB = 10;
    localparam int DW   = 32;
    localparam int T    = 4;
    localparam int TOW  = 3;

    localparam logic [1:0] S_OK  = 2'b00;
    localparam logic [1:0] S_INV = 2'b01;
    localparam logic [1:0] S_TO  = 2'b10;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic        inv;
        int          hold;
        logic        junk;
    } txn_t;

    logic clk;
    logic res;
    int   checks;
    int   failures;
    int   txn_no;

    logic [31:0] mem [256];

    rf_cmd_if #(.RF_ADDR_MSB(AMSB), .DATA_WIDTH(DW)) cmd_bus ();
    rf_bus_if #(.RF_ADDR_MSB(AMSB), .DATA_WIDTH(DW)) rf_bus ();

    rf_access_master #(
        .RF_ADDR_MSB    (AMSB),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T),
        .TO_WIDTH       (TOW)
    ) dut (
        .clk (clk),
        .res (res),
        .cmd (cmd_bus),
        .rf  (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (txn %0d)", tag, got, exp, txn_no);
        end
    endtask

    // Register-file behaviour for one cycle: complete lat cycles after the strobe,
    // optionally throw a stale completion into the accept/strobe cycles.
    task automatic drive_slave(input int c, input txn_t t);
        logic complete;
        complete = (c == t.lat + 1);
        rf_bus.access_complete = complete || (t.junk && c <= 1);
        rf_bus.invalid_address = complete ? t.inv : 1'($urandom);
        if (complete && !t.wr && !t.inv) rf_bus.read_data = mem[t.addr];
        else                             rf_bus.read_data = $urandom;
        if (complete && t.wr && !t.inv) mem[t.addr] = t.wdata;
    endtask

    task automatic junk_cmd(input logic junk);
        cmd_bus.cmd_valid = junk;
        cmd_bus.cmd_write = 1'($urandom);
        cmd_bus.cmd_addr  = 8'($urandom);
        cmd_bus.cmd_wdata = $urandom;
    endtask

    task automatic run_txn(input txn_t t);
        int          c;
        int          seen;
        int          exp_cyc;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        logic [1:0]  st0;
        logic [31:0] rd0;
        logic        bad_strobe;
        logic        bad_hold;
        logic        bad_rdy;

        // Expected outcome from the timing rules: completion at cycle lat+1 wins
        // if it arrives no later than the last wait cycle (T+1).
        if (t.lat <= T) begin
            exp_cyc = t.lat + 2;
            exp_st  = t.inv ? S_INV : S_OK;
            exp_rd  = (!t.wr && !t.inv) ? mem[t.addr] : 32'h0;
        end else begin
            exp_cyc = T + 2;
            exp_st  = S_TO;
            exp_rd  = 32'h0;
        end
        $display("txn %0d wr=%0b addr=0x%02h wdata=0x%08h lat=%0d inv=%0b hold=%0d exp_status=%0d",
                 txn_no, t.wr, t.addr, t.wdata, t.lat, t.inv, t.hold, exp_st);

        // cycle 0: accept
        c = 0;
        check_eq("cmd_ready_idle", 32'(cmd_bus.cmd_ready), 32'd1);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_write = t.wr;
        cmd_bus.cmd_addr  = t.addr;
        cmd_bus.cmd_wdata = t.wdata;
        drive_slave(c, t);
        @(negedge clk);
        c = 1;

        // cycle 1: strobe
        junk_cmd(t.junk);
        check_eq("write_en_strobe", 32'(rf_bus.write_en), 32'(t.wr));
        check_eq("read_en_strobe", 32'(rf_bus.read_en), 32'(!t.wr));
        check_eq("address_strobe", 32'(rf_bus.address), 32'(t.addr));
        check_eq("write_data_strobe", rf_bus.write_data, t.wdata);
        drive_slave(c, t);
        @(negedge clk);
        c = 2;

        // wait for the response, bounded
        seen = 0;
        bad_strobe = 1'b0;
        while (seen == 0 && c < 64) begin
            if (cmd_bus.rsp_valid === 1'b1) begin
                seen = c;
            end else begin
                if (rf_bus.read_en !== 1'b0 || rf_bus.write_en !== 1'b0) bad_strobe = 1'b1;
                if (rf_bus.address !== t.addr || rf_bus.write_data !== t.wdata) bad_strobe = 1'b1;
                if (cmd_bus.cmd_ready !== 1'b0) bad_strobe = 1'b1;
                drive_slave(c, t);
                @(negedge clk);
                c++;
            end
        end
        check_eq("wait_quiet", 32'(bad_strobe), 32'd0);
        if (seen == 0) begin
            check_eq("rsp_within_bound", 32'd0, 32'd1);
            cmd_bus.cmd_valid = 1'b0;
            rf_bus.access_complete = 1'b0;
            res = 1'b1;
            @(negedge clk);
            res = 1'b0;
            @(negedge clk);
            return;
        end
        check_eq("rsp_cycle", 32'(seen), 32'(exp_cyc));
        check_eq("rsp_status", 32'(cmd_bus.rsp_status), 32'(exp_st));
        check_eq("rsp_rdata", cmd_bus.rsp_rdata, exp_rd);
        check_eq("rsp_write", 32'(cmd_bus.rsp_write), 32'(t.wr));
        st0 = cmd_bus.rsp_status;
        rd0 = cmd_bus.rsp_rdata;

        // backpressure: response must hold, no new command taken
        bad_hold = 1'b0;
        bad_rdy  = (cmd_bus.cmd_ready !== 1'b0);
        for (int i = 0; i < t.hold; i++) begin
            drive_slave(c, t);
            junk_cmd(t.junk);
            @(negedge clk);
            c++;
            if (cmd_bus.rsp_valid !== 1'b1 || cmd_bus.rsp_status !== st0 ||
                cmd_bus.rsp_rdata !== rd0 || cmd_bus.rsp_write !== t.wr) bad_hold = 1'b1;
            if (rf_bus.read_en !== 1'b0 || rf_bus.write_en !== 1'b0 ||
                rf_bus.address !== t.addr || rf_bus.write_data !== t.wdata) bad_hold = 1'b1;
            if (cmd_bus.cmd_ready !== 1'b0) bad_rdy = 1'b1;
        end
        check_eq("rsp_hold_stable", 32'(bad_hold), 32'd0);
        check_eq("cmd_ready_low_in_resp", 32'(bad_rdy), 32'd0);

        // handshake, then IDLE on the next cycle
        drive_slave(c, t);
        cmd_bus.rsp_ready = 1'b1;
        @(negedge clk);
        cmd_bus.rsp_ready = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        rf_bus.access_complete = 1'b0;
        check_eq("rsp_valid_after_hs", 32'(cmd_bus.rsp_valid), 32'd0);
        check_eq("cmd_ready_after_hs", 32'(cmd_bus.cmd_ready), 32'd1);
        txn_no++;
    endtask

    task automatic run_reset_mid();
        logic bad;
        $display("txn %0d reset during wait", txn_no);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_write = 1'b0;
        cmd_bus.cmd_addr  = 8'h33;
        cmd_bus.cmd_wdata = 32'h0;
        rf_bus.access_complete = 1'b0;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_cmd_ready_in_reset", 32'(cmd_bus.cmd_ready), 32'd0);
        res = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_strobes", 32'({rf_bus.read_en, rf_bus.write_en}), 32'd0);
        check_eq("rst_mid_rsp_valid", 32'(cmd_bus.rsp_valid), 32'd0);
        check_eq("rst_mid_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        rf_bus.access_complete = 1'b1;
        rf_bus.invalid_address = 1'b0;
        rf_bus.read_data = 32'hA5A5A5A5;
        @(negedge clk);
        rf_bus.access_complete = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_bus.rsp_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check_eq("rst_mid_late_completion", 32'(bad), 32'd0);
        txn_no++;
    endtask

    initial begin
        txn_t dir_q[$];
        txn_t t;

        checks   = 0;
        failures = 0;
        txn_no   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h85] = 32'h12345678;

        res = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_write = 1'b0;
        cmd_bus.cmd_addr  = '0;
        cmd_bus.cmd_wdata = '0;
        cmd_bus.rsp_ready = 1'b0;
        rf_bus.read_data = '0;
        rf_bus.invalid_address = 1'b0;
        rf_bus.access_complete = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        check_eq("reset_rsp_valid", 32'(cmd_bus.rsp_valid), 32'd0);
        check_eq("reset_rsp_write", 32'(cmd_bus.rsp_write), 32'd0);
        check_eq("reset_rsp_status", 32'(cmd_bus.rsp_status), 32'd0);
        check_eq("reset_rsp_rdata", cmd_bus.rsp_rdata, 32'd0);
        check_eq("reset_strobes", 32'({rf_bus.read_en, rf_bus.write_en}), 32'd0);
        check_eq("reset_address", 32'(rf_bus.address), 32'd0);
        check_eq("reset_write_data", rf_bus.write_data, 32'd0);
        res = 1'b0;
        @(negedge clk);
        check_eq("cmd_ready_after_reset", 32'(cmd_bus.cmd_ready), 32'd1);

        // scenarios from the test plan, then random traffic
        dir_q.push_back('{1'b1, 8'h00, 32'hDEADBEEF, 1, 1'b0, 0,  1'b0});
        dir_q.push_back('{1'b0, 8'h85, 32'h0,        4, 1'b0, 0,  1'b0});
        dir_q.push_back('{1'b0, 8'h40, 32'h0,        1, 1'b1, 1,  1'b0});
        dir_q.push_back('{1'b0, 8'h22, 32'h0,        7, 1'b0, 3,  1'b0});
        dir_q.push_back('{1'b0, 8'h00, 32'h0,        2, 1'b0, 0,  1'b0});
        dir_q.push_back('{1'b1, 8'h10, 32'hCAFEF00D, 3, 1'b0, 10, 1'b1});
        dir_q.push_back('{1'b0, 8'h10, 32'h0,        T, 1'b0, 0,  1'b1});
        foreach (dir_q[i]) run_txn(dir_q[i]);

        run_reset_mid();

        for (int n = 0; n < 40; n++) begin
            t.wr    = 1'($urandom);
            t.addr  = 8'($urandom);
            t.wdata = $urandom;
            t.lat   = int'($urandom_range(1, T + 3));
            t.inv   = ($urandom_range(0, 3) == 0);
            t.hold  = int'($urandom_range(0, 3));
            t.junk  = 1'($urandom);
            run_txn(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
